// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Optional feature macro: REGARB_RR_EN (round-robin contention handling).
package regfile_pkg;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NREGS = 4;

    // Requester identities, also used as the round-robin pointer encoding.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_wr_arbiter_slot.sv
// One-entry holding slot: captures a request on load, empties when drained by a grant.
// A load on the same edge as a drain wins, so a granted slot can refill immediately.
module regfile_wr_arbiter_slot
    import regfile_pkg::*;
#(
    parameter int SDW = DW,
    parameter int SAW = AW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           drain,
    input  logic [SAW-1:0] in_addr,
    input  logic [SDW-1:0] in_data,
    output logic           full,
    output logic [SAW-1:0] addr,
    output logic [SDW-1:0] data
);

    logic           full_r;
    logic [SAW-1:0] addr_r;
    logic [SDW-1:0] data_r;

    // Slot storage: reset empties, load captures, drain releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 1'b0;
            addr_r <= {SAW{1'b0}};
            data_r <= {SDW{1'b0}};
        end else if (load) begin
            full_r <= 1'b1;
            addr_r <= in_addr;
            data_r <= in_data;
        end else if (drain) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign full = full_r;
    assign addr = addr_r;
    assign data = data_r;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between ALU (req0) and load (req1)
// writeback sources. Each source has a one-entry slot; one full slot is granted per
// cycle and drives a registered write strobe.
// Optional feature macro: REGARB_RR_EN -- round-robin on contention; when undefined,
// requester 0 always wins contention and no pointer exists.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int DW    = regfile_pkg::DW,
    parameter int AW    = regfile_pkg::AW,
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [AW-1:0]    req0_addr,
    input  logic [DW-1:0]    req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [AW-1:0]    req1_addr,
    input  logic [DW-1:0]    req1_data,
    output logic             write,
    output logic [AW-1:0]    wraddr,
    output logic [DW-1:0]    wrdata,
    output logic [NREGS-1:0] pend_mask,
    output logic             err_oor
);

    localparam logic [AW:0] NREGS_L = (AW+1)'(NREGS);

    // One-hot decode of an in-range address; out-of-range addresses match no bit.
    function automatic logic [NREGS-1:0] dec_addr(input logic [AW-1:0] a, input logic en);
        logic [NREGS-1:0] m;
        m = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            m[i] = en && (a == AW'(i));
        end
        return m;
    endfunction

    logic          full0_s, full1_s;
    logic [AW-1:0] addr0_s, addr1_s;
    logic [DW-1:0] data0_s, data1_s;
    logic          grant0_s, grant1_s;
    logic          any_grant_s;
    logic [AW-1:0] gaddr_s;
    logic [DW-1:0] gdata_s;
    logic          g_inrange_s;
    logic          write_r;
    logic [AW-1:0] wraddr_r;
    logic [DW-1:0] wrdata_r;
    logic          err_oor_r;

    assign req0_ready = ~full0_s | grant0_s;
    assign req1_ready = ~full1_s | grant1_s;

    regfile_wr_arbiter_slot #(.SDW(DW), .SAW(AW)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .load    (req0_valid & req0_ready),
        .drain   (grant0_s),
        .in_addr (req0_addr),
        .in_data (req0_data),
        .full    (full0_s),
        .addr    (addr0_s),
        .data    (data0_s)
    );

    regfile_wr_arbiter_slot #(.SDW(DW), .SAW(AW)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .load    (req1_valid & req1_ready),
        .drain   (grant1_s),
        .in_addr (req1_addr),
        .in_data (req1_data),
        .full    (full1_s),
        .addr    (addr1_s),
        .data    (data1_s)
    );

`ifdef REGARB_RR_EN
    req_id_e rr_ptr_r;

    // Grant from slot occupancy; the pointer breaks ties only when both are full.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (full0_s && full1_s) begin
            if (rr_ptr_r == REQ_ALU) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else begin
            grant0_s = full0_s;
            grant1_s = full1_s;
        end
    end

    // Pointer moves to the loser after every contention grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= REQ_ALU;
        end else if (full0_s && full1_s) begin
            rr_ptr_r <= grant0_s ? REQ_MEM : REQ_ALU;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Fixed priority: slot 0 always wins, slot 1 only when slot 0 is empty.
    always_comb begin
        grant0_s = full0_s;
        grant1_s = full1_s & ~full0_s;
    end
`endif

    // Select the granted slot's contents and classify its address.
    always_comb begin
        any_grant_s = grant0_s | grant1_s;
        if (grant1_s) begin
            gaddr_s = addr1_s;
            gdata_s = data1_s;
        end else begin
            gaddr_s = addr0_s;
            gdata_s = data0_s;
        end
        g_inrange_s = ({1'b0, gaddr_s} < NREGS_L);
    end

    // Output stage: one-cycle write pulse per in-range grant; out-of-range grants
    // suppress the strobe and set the sticky error instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_r   <= 1'b0;
            wraddr_r  <= {AW{1'b0}};
            wrdata_r  <= {DW{1'b0}};
            err_oor_r <= 1'b0;
        end else if (any_grant_s && g_inrange_s) begin
            write_r   <= 1'b1;
            wraddr_r  <= gaddr_s;
            wrdata_r  <= gdata_s;
        end else if (any_grant_s) begin
            write_r   <= 1'b0;
            err_oor_r <= 1'b1;
        end else begin
            write_r   <= 1'b0;
        end
    end

    assign write     = write_r;
    assign wraddr    = wraddr_r;
    assign wrdata    = wrdata_r;
    assign err_oor   = err_oor_r;
    assign pend_mask = dec_addr(addr0_s, full0_s)
                     | dec_addr(addr1_s, full1_s)
                     | dec_addr(wraddr_r, write_r);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed, table-driven bench for regfile_wr_arbiter. Expectations for the
// contention rows follow REGARB_RR_EN (round-robin) or its absence (fixed priority).
module tb_regfile_wr_arbiter;

`ifdef REGARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_addr, req1_addr;
    logic [15:0] req0_data, req1_data;
    logic        write;
    logic [3:0]  wraddr;
    logic [15:0] wrdata;
    logic [3:0]  pend_mask;
    logic        err_oor;

    int nchecks = 0;
    int nerrors = 0;

    regfile_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .write      (write),
        .wraddr     (wraddr),
        .wrdata     (wrdata),
        .pend_mask  (pend_mask),
        .err_oor    (err_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [3:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic        r0;     // expected ready before the edge
        logic        r1;
        logic        w;      // expected after the edge
        logic        chk_data;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  pend;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                                 input logic v1, input logic [3:0] a1, input logic [15:0] d1,
                                 input logic r0, input logic r1, input logic w,
                                 input logic cd, input logic [3:0] wa, input logic [15:0] wd,
                                 input logic [3:0] pend, input logic err);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.w = w; v.chk_data = cd; v.wa = wa; v.wd = wd;
        v.pend = pend; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 2: single req0 write to r2.
        addv(1'b1, 4'd2, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'b0100, 1'b0);
        addv(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 16'hBEEF, 4'b0100, 1'b0);
        addv(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'hBEEF, 4'b0000, 1'b0);
        // Tests 3/4: both valid for 5 cycles, then drain.
        addv(1'b1, 4'd1, 16'h1111, 1'b1, 4'd3, 16'h3333, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'hBEEF, 4'b1010, 1'b0);
        addv(1'b1, 4'd1, 16'h1111, 1'b1, 4'd3, 16'h3333, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h1111, 4'b1010, 1'b0);
        addv(1'b1, 4'd1, 16'h1111, 1'b1, 4'd3, 16'h3333, !RR,  RR,   1'b1, 1'b1,
             RR ? 4'd3 : 4'd1, RR ? 16'h3333 : 16'h1111, 4'b1010, 1'b0);
        addv(1'b1, 4'd1, 16'h1111, 1'b1, 4'd3, 16'h3333, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h1111, 4'b1010, 1'b0);
        addv(1'b1, 4'd1, 16'h1111, 1'b1, 4'd3, 16'h3333, !RR,  RR,   1'b1, 1'b1,
             RR ? 4'd3 : 4'd1, RR ? 16'h3333 : 16'h1111, 4'b1010, 1'b0);
        addv(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h1111, 4'b1010, 1'b0);
        addv(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 16'h3333, 4'b1000, 1'b0);
        addv(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 16'h3333, 4'b0000, 1'b0);
        // Test 5: out-of-range req1 address.
        addv(1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 16'h3333, 4'b0000, 1'b0);
        addv(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'b0000, 1'b1);
        addv(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'b0000, 1'b1);

        // Test 1: reset held 2 cycles with both valids high.
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 4'd2; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_addr = 4'd3; req1_data = 16'hBBBB;
        step();
        step();
        chk("rst_write", write, 1'b0);
        chk("rst_wraddr", wraddr, 4'd0);
        chk("rst_wrdata", wrdata, 16'h0000);
        chk("rst_pend", pend_mask, 4'b0000);
        chk("rst_err", err_oor, 1'b0);
        chk("rst_ready0", req0_ready, 1'b1);
        chk("rst_ready1", req1_ready, 1'b1);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        chk("post_rst_write", write, 1'b0);
        chk("post_rst_pend", pend_mask, 4'b0000);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
            #1;
            chk($sformatf("v%0d_ready0", i), req0_ready, vecs[i].r0);
            chk($sformatf("v%0d_ready1", i), req1_ready, vecs[i].r1);
            step();
            chk($sformatf("v%0d_write", i), write, vecs[i].w);
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_wraddr", i), wraddr, vecs[i].wa);
                chk($sformatf("v%0d_wrdata", i), wrdata, vecs[i].wd);
            end
            chk($sformatf("v%0d_pend", i), pend_mask, vecs[i].pend);
            chk($sformatf("v%0d_err", i), err_oor, vecs[i].err);
        end

        // Test 6: fill both slots, then reset for one cycle.
        req0_valid = 1'b1; req0_addr = 4'd0; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_addr = 4'd1; req1_data = 16'h5555;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("t6_full_pend", pend_mask, 4'b0011);
        chk("t6_full_write", write, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_write", write, 1'b0);
        chk("t6_pend", pend_mask, 4'b0000);
        chk("t6_err_cleared", err_oor, 1'b0);
        chk("t6_wraddr", wraddr, 4'd0);
        chk("t6_ready0", req0_ready, 1'b1);
        chk("t6_ready1", req1_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t6_nowrite%0d", k), write, 1'b0);
            chk($sformatf("t6_nopend%0d", k), pend_mask, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
